switch_allocator: RTL
=====================

# switch_allocator

Per-output wormhole switch allocator for the 5-port mesh router. It turns the head-of-FIFO requests from the five input buffers into one 3-bit input-select per output port (`sa1`..`sa5`). The existing crossbar pop-control logic combines these selects with the input valid bits to pop FIFOs and steer the crossbar. Arbitration is round-robin per output, and an output stays locked to its winning input from head flit to tail flit.

## Interface
Parameters:
- `NPORT`, 5, number of router ports (inputs = outputs); only 5 is supported.
- `SELW`, 3, width of a port code.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in 5: bit i-1 set when input i's FIFO is non-empty; the same signal as the crossbar `vc` bits.
- `req_dst` in 15: destination port code of input i's head flit, in bits [3i-1:3i-3]. Codes 3'b001..3'b101 select output 1..5; other codes are invalid.
- `req_head` in 5: input i's FIFO-head flit is a head flit.
- `req_tail` in 5: input i's FIFO-head flit is a tail flit. Head and tail both set means a single-flit packet.
- `out_ready` in 5: downstream of output k can accept a flit this cycle.
- `sa1`..`sa5` out 3 each: input select for output k. 3'b001..3'b101 selects input 1..5; 3'b000 means none.
- `lock` out 5: output k is currently owned by a packet.

## Operation
Each output k has three pieces of state:
- `owner_k`, a 3-bit port code; 000 when the output is idle.
- `ptr_k`, the round-robin priority pointer, a port code 001..101.
- `lock[k]`, which equals (`owner_k` != 000).

Idle output k:
- Candidate set: all inputs i with `req_valid[i]` & `req_head[i]` & `req_dst[i]` == k.
- Inputs that currently own some output are excluded.
- Winner is the first candidate found scanning from `ptr_k` upward, wrapping 5→1. It is registered into `owner_k`.
- No candidates: state unchanged.
- Invalid `req_dst` codes and non-head flits never request.

Locked output k:
- `owner_k` is held regardless of `req_dst` or `req_head`.
- `fire_k` = `out_ready[k]` & `req_valid[owner_k]`.
- On `fire_k` & `req_tail[owner_k]`, the next state is `owner_k` = 000 and `ptr_k` = owner_k+1, wrapping 5→1.

Select output:
- `sa_k` = `owner_k` when `lock[k]` & `out_ready[k]`, else 3'b000.
- This is combinational from registered state and `out_ready`, so backpressure stalls the pop in the same cycle.

Reset values:
- All `owner_k` = 000.
- All `ptr_k` = 001.
- `lock` = 5'b0.
- All `sa_k` = 000.

## Timing
- Head flit presented in cycle t with output k idle: `lock[k]` rises at t+1, and `sa_k` = owner at t+1 if `out_ready[k]`. The first pop happens at t+1, so arbitration latency is 1 cycle.
- Each body flit pops in the cycle `fire_k` holds. Throughput is 1 flit/cycle/output.
- Tail pop in cycle t: output k is idle at t+1 and `sa_k` = 000 at t+1. The earliest next grant is registered at t+2, giving one dead cycle per packet boundary.
- Input bubble (`req_valid[owner]` low) mid-packet: lock held, and `sa_k` still shows the owner. No pop occurs because the crossbar gates on valid.
- `out_ready[k]` low mid-packet: lock held, `sa_k` = 000, no pop.
- Reset asserted mid-packet: next cycle all locks clear and all pointers return to 001. The input FIFOs are not touched, so flushing them is the router-level reset's job.
- Two outputs arbitrate in the same cycle: independent, because one input can only request one destination.

## Structure
- Shared package `noc_pkg` holds:
  - `NPORT`
  - port codes `PORT_NONE`=3'b000 and `PORT_1`..`PORT_5`=3'b001..3'b101
  - the flit-type encoding (head/body/tail bits)
- One sub-module, `rr_arbiter`: 5-bit request vector plus 3-bit pointer in, 3-bit one-of-5 port code (or `PORT_NONE`) out. It is purely combinational and instantiated once per output.
- Owner, pointer and fire logic stay in `switch_allocator`.
- Expected size is ~200 lines.

## Test plan
- **Reset:** hold `rst` 2 cycles with all requests active. Required: `sa1`..`sa5` = 000 and `lock` = 0 during and on the first cycle after reset.
- **Single-flit packet:**
  - Stimulus: input 2 `req_valid`, head=tail=1, `req_dst`=3'b100, `out_ready`=all 1.
  - Required: cycle 1 `sa4`=010 and `lock[3]`=1; cycle 2 `lock[3]`=0 and `sa4`=000; `ptr_4` advanced to 011.
- **Contention:**
  - Stimulus: inputs 1, 3, 5 send 2-flit packets to output 2, always valid, `out_ready` all 1.
  - Required grant order from reset: input 1, then 3, then 5. `sa2` sequence is 001,001,000,011,011,000,101,101.
- **Wormhole hold:**
  - Stimulus: input 4 owns output 1 with a 4-flit packet; input 2 raises a head flit to output 1 mid-packet.
  - Required: `sa1` stays 100 until the tail pops; input 2 is granted 2 cycles after the tail pop.
- **Backpressure:**
  - Stimulus: `out_ready[0]` low for 3 cycles during an owned body flit.
  - Required: `sa1`=000 for exactly those cycles and `lock[0]` stays 1; the flit count delivered equals the packet length.
- **Reset mid-packet:**
  - Stimulus: `rst` asserted while output 3 is locked by input 5.
  - Required: next cycle `lock[2]`=0 and `sa3`=000; the post-reset grant follows pointer 001.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port codes, flit-type encoding and small
// port-code helpers used by the allocator and its arbiters.
package noc_pkg;

  localparam int NPORT = 5;
  localparam int PORTW = 3;

  typedef logic [PORTW-1:0] port_t;

  localparam port_t PORT_NONE = 3'b000;
  localparam port_t PORT_1    = 3'b001;
  localparam port_t PORT_2    = 3'b010;
  localparam port_t PORT_3    = 3'b011;
  localparam port_t PORT_4    = 3'b100;
  localparam port_t PORT_5    = 3'b101;

  // {head, tail}; both set marks a single-flit packet
  typedef enum logic [1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_TAIL   = 2'b01,
    FLIT_HEAD   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  function automatic logic [NPORT-1:0] port_onehot(input port_t code);
    for (int i = 0; i < NPORT; i++) begin
      port_onehot[i] = (code == port_t'(i + 1));
    end
  endfunction

  function automatic port_t port_next(input port_t code);
    return (code == PORT_5) ? PORT_1 : port_t'(code + port_t'(1));
  endfunction

endpackage

// File: rtl/switch_allocator_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above the pointer,
// wrapping 5 -> 1. Returns a port code, or PORT_NONE with no requests.
module rr_arbiter
  import noc_pkg::*;
(
  input  logic [NPORT-1:0] req_i,
  input  port_t            ptr_i,
  output port_t            grant_o
);

  int         base;
  logic [2:0] idx;

  always_comb begin
    // NOTE: every combinationally assigned variable gets a default first, so no path can leave it holding a stale value (a latch).
    grant_o = PORT_NONE;
    idx     = '0;
    base    = (ptr_i >= PORT_1 && ptr_i <= PORT_5) ? int'(ptr_i) - 1 : 0;
    // Walk from the far end back towards the pointer so the nearest requester is written last.
    for (int off = NPORT - 1; off >= 0; off--) begin
      idx = 3'((base + off) % NPORT);
      if (req_i[idx]) grant_o = port_t'(idx + 3'd1);
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Per-output wormhole switch allocator: round-robin grant on head flits,
// output held by its owner until the tail flit pops.
module switch_allocator
  import noc_pkg::port_t, noc_pkg::PORT_NONE, noc_pkg::PORT_1,
         noc_pkg::port_onehot, noc_pkg::port_next;
#(
  parameter int NPORT = 5,
  parameter int SELW  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NPORT-1:0]      req_valid,
  input  logic [NPORT*SELW-1:0] req_dst,
  input  logic [NPORT-1:0]      req_head,
  input  logic [NPORT-1:0]      req_tail,
  input  logic [NPORT-1:0]      out_ready,
  output logic [SELW-1:0]       sa1,
  output logic [SELW-1:0]       sa2,
  output logic [SELW-1:0]       sa3,
  output logic [SELW-1:0]       sa4,
  output logic [SELW-1:0]       sa5,
  output logic [NPORT-1:0]      lock
);

  port_t            owner_q [NPORT];
  port_t            owner_d [NPORT];
  port_t            ptr_q   [NPORT];
  port_t            ptr_d   [NPORT];
  port_t            grant   [NPORT];
  port_t            sa      [NPORT];
  logic [NPORT-1:0] arb_req [NPORT];
  logic [NPORT-1:0] owned;
  logic [NPORT-1:0] fire;

  // An input already streaming into one output may not win another.
  always_comb begin
    owned = '0;
    for (int k = 0; k < NPORT; k++) owned |= port_onehot(owner_q[k]);
  end

  always_comb begin
    for (int k = 0; k < NPORT; k++) begin
      for (int i = 0; i < NPORT; i++) begin
        arb_req[k][i] = req_valid[i] & req_head[i] & ~owned[i] &
                        (req_dst[i*SELW +: SELW] == port_t'(k + 1));
      end
    end
  end

  for (genvar k = 0; k < NPORT; k++) begin : g_arb
    rr_arbiter u_arb (
      .req_i   (arb_req[k]),
      .ptr_i   (ptr_q[k]),
      .grant_o (grant[k])
    );
  end

  always_comb begin
    for (int k = 0; k < NPORT; k++) begin
      owner_d[k] = owner_q[k];
      ptr_d[k]   = ptr_q[k];
      fire[k]    = out_ready[k] & |(req_valid & port_onehot(owner_q[k]));
      if (owner_q[k] == PORT_NONE) begin
        if (grant[k] != PORT_NONE) owner_d[k] = grant[k];
      end else if (fire[k] && |(req_tail & port_onehot(owner_q[k]))) begin
        owner_d[k] = PORT_NONE;
        ptr_d[k]   = port_next(owner_q[k]);
      end
    end
  end

  // NOTE: owner and pointer arrays are control state, not storage, so every entry is reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NPORT; k++) begin
        owner_q[k] <= PORT_NONE;
        ptr_q[k]   <= PORT_1;
      end
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // Select is unregistered on out_ready so backpressure stalls the pop in the same cycle.
  always_comb begin
    for (int k = 0; k < NPORT; k++) begin
      lock[k] = (owner_q[k] != PORT_NONE);
      sa[k]   = (lock[k] && out_ready[k]) ? owner_q[k] : PORT_NONE;
    end
  end

  assign sa1 = sa[0];
  assign sa2 = sa[1];
  assign sa3 = sa[2];
  assign sa4 = sa[3];
  assign sa5 = sa[4];

endmodule
